// File: rtl/fib_index.sv
// rtl/fib_index.sv - Fibonacci index lookup for a 32-bit unsigned value
//
// Purpose: walks the Fibonacci sequence F(0)=0, F(1)=1, ... one term per clock
// until it finds the queried value. It then reports either the exact index or
// the largest index whose term is below the value. F(47) is the last term that
// fits in 32 bits, so the walk always stops by index 47.
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   in_valid   in   1   query present on in_value
//   in_ready   out  1   block can accept a query this cycle (IDLE, not in reset)
//   in_value   in   32  unsigned value to look up
//   out_valid  out  1   result present (DONE state)
//   out_ready  in   1   consumer takes the result this cycle
//   out_index  out  6   Fibonacci index result
//   out_is_fib out  1   1 = in_value is exactly a Fibonacci number
module fib_index (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_index,
    output logic        out_is_fib
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [5:0] LAST_IDX  = 6'd47;

    logic [1:0]  r_state;
    logic [31:0] r_target;
    // prev only ever holds terms up to F(47). cur reaches F(48), which needs
    // 33 bits. Both are kept 33 bits wide so the sum and compares never wrap.
    logic [32:0] r_prev;
    logic [32:0] r_cur;
    logic [5:0]  r_idx;
    logic [5:0]  r_out_index;
    logic        r_out_is_fib;

    logic [32:0] w_target_ext;
    logic        w_eq;
    logic        w_gt;
    logic        w_last;

    assign w_target_ext = {1'b0, r_target};
    assign w_eq         = (r_prev == w_target_ext);
    assign w_gt         = (r_prev > w_target_ext);
    assign w_last       = (r_idx == LAST_IDX);

    assign in_ready   = (r_state == ST_IDLE) && !reset;
    assign out_valid  = (r_state == ST_DONE);
    assign out_index  = r_out_index;
    assign out_is_fib = r_out_is_fib;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_target     <= 32'd0;
            r_prev       <= 33'd0;
            r_cur        <= 33'd1;
            r_idx        <= 6'd0;
            r_out_index  <= 6'd0;
            r_out_is_fib <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_target <= in_value;
                        r_prev   <= 33'd0;
                        r_cur    <= 33'd1;
                        r_idx    <= 6'd0;
                        r_state  <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    // The equality test comes first, so the duplicate term 1
                    // resolves to index 1, the first time prev equals 1.
                    if (w_eq) begin
                        r_out_index  <= r_idx;
                        r_out_is_fib <= 1'b1;
                        r_state      <= ST_DONE;
                    end else if (w_gt) begin
                        // prev is 0 at idx 0, so prev can only exceed the
                        // target when idx is at least 1. idx-1 never underflows.
                        r_out_index  <= r_idx - 6'd1;
                        r_out_is_fib <= 1'b0;
                        r_state      <= ST_DONE;
                    end else if (w_last) begin
                        r_out_index  <= LAST_IDX;
                        r_out_is_fib <= 1'b0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_prev <= r_cur;
                        r_cur  <= r_prev + r_cur;
                        r_idx  <= r_idx + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_index.sv
// tb/tb_fib_index.sv - directed self-checking bench for fib_index
module tb_fib_index;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic        out_is_fib;

    int passed = 0;
    int total  = 0;
    int saw_valid = 0;
    logic watch_valid = 1'b0;

    fib_index dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_is_fib (out_is_fib)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (watch_valid && out_valid) saw_valid++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one query, count edges to out_valid, check result, then consume.
    // While the search runs, in_valid is held high with an unrelated value;
    // that value must be ignored outside IDLE.
    task automatic query(input string tag, input logic [31:0] val,
                         input int exp_idx, input logic exp_fib, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        in_value = val;
        tick();
        in_value = 32'd3;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_index"}, out_index, exp_idx);
        check({tag, "_is_fib"}, out_is_fib, exp_fib);
        check({tag, "_in_ready_done"}, in_ready, 0);
        // Offer a new query in the consume cycle; it must not be taken.
        in_valid  = 1'b1;
        in_value  = 32'd8;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_retain_idx"}, out_index, exp_idx);
        check({tag, "_retain_fib"}, out_is_fib, exp_fib);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        out_ready = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_is_fib", out_is_fib, 0);
        check("rst_in_ready_low", in_ready, 1);

        query("q0",    32'd0,          0,  1'b1, 1);
        query("q1",    32'd1,          1,  1'b1, 2);
        query("q55",   32'h0000_0037,  10, 1'b1, 11);
        query("q4",    32'd4,          4,  1'b0, 6);
        query("qf47",  32'hB119_24E1,  47, 1'b1, 48);
        query("qmax",  32'hFFFF_FFFF,  47, 1'b0, 48);
        query("q100",  32'd100,        11, 1'b0, 13);

        // Backpressure: result must stay put for 5 cycles with out_ready low.
        in_valid = 1'b1;
        in_value = 32'd21;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("bp_latency", n, 9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_index", out_index, 8);
            check("bp_is_fib", out_is_fib, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_consumed", out_valid, 0);
        check("bp_ready_after", in_ready, 1);

        // Reset in the middle of a long search: no result may ever appear.
        watch_valid = 1'b1;
        in_valid = 1'b1;
        in_value = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_value = 32'd5;
        tick();
        check("mid_rst_in_ready", in_ready, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_idle_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        for (int i = 0; i < 60; i++) tick();
        check("mid_rst_never_valid", saw_valid, 0);
        watch_valid = 1'b0;
        query("q8", 32'd8, 6, 1'b1, 7);

        // Reset while a result is waiting in DONE discards it.
        in_valid = 1'b1;
        in_value = 32'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("done_rst_pre", out_valid, 1);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("done_rst_valid", out_valid, 0);
        check("done_rst_index", out_index, 0);
        check("done_rst_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fib_index.md
FIB_INDEX -- requirements
Module: fib_index

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-003 SHALL have port in_valid  input  1  query value present on in_value.
REQ-004 SHALL have port in_ready  output  1  block can accept a query this cycle.
REQ-005 SHALL have port in_value  input  32  unsigned value to look up.
REQ-006 SHALL have port out_valid  output  1  result present on out_index/out_is_fib.
REQ-007 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-008 SHALL have port out_index  output  6  Fibonacci index result.
REQ-009 SHALL have port out_is_fib  output  1  1 = in_value is exactly a Fibonacci number.

Function
REQ-010 SHALL use sequence F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2); F(47)=2971215073 is the largest 32-bit term.
REQ-011 SHALL implement states IDLE, SEARCH, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE with reset low; out_valid=1 only in DONE.
REQ-013 Accept: in IDLE with in_valid=1 at an edge, SHALL latch target=in_value, load prev=0, cur=1, idx=0, go to SEARCH.
REQ-014 SEARCH, per edge, evaluated in priority order:
  - prev==target -> DONE, out_is_fib=1, out_index=idx.
  - prev>target -> DONE, out_is_fib=0, out_index=idx-1 (largest k with F(k)<target).
  - idx==47 -> DONE, out_is_fib=0, out_index=47.
  - else prev<=cur, cur<=prev+cur, idx<=idx+1.
REQ-015 Duplicate value 1 SHALL resolve to index 1 (first match wins).
REQ-016 cur SHALL be held at 33 bits; the overflowed term F(48) SHALL never produce a match or a wrap-around compare.
REQ-017 Latency: out_valid SHALL rise exactly S edges after the accept edge, S = number of SEARCH edges = (terminating idx)+1; maximum 48.
REQ-018 DONE SHALL hold out_valid, out_index and out_is_fib stable until out_ready=1 at an edge, then go to IDLE.
REQ-019 SHALL NOT accept a new query in the cycle a result is consumed; in_ready rises the cycle after.
REQ-020 in_value and in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-021 out_index and out_is_fib SHALL retain the last result after consumption until the next DONE entry.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, out_valid=0, out_index=0, out_is_fib=0, prev=0, cur=1, idx=0, in any state.
REQ-023 in_ready SHALL be 0 in any cycle where reset=1.
REQ-024 Reset mid-SEARCH or mid-DONE SHALL discard the query with no result ever presented.
REQ-025 reset SHALL override a simultaneous in_valid or out_ready handshake.

Verification
REQ-026 in_value=0 accepted, out_ready=1 -> out_valid 1 edge after accept, out_index=0, out_is_fib=1.
REQ-027 in_value=1 -> out_index=1, out_is_fib=1, latency 2; in_value=0x0000_0037 (55) -> out_index=10, out_is_fib=1, latency 11.
REQ-028 in_value=4 -> out_index=4, out_is_fib=0, latency 6; in_value=0xB11924E1 (F(47)) -> out_index=47, out_is_fib=1, latency 48.
REQ-029 in_value=0xFFFFFFFF -> out_index=47, out_is_fib=0, latency 48, no false match.
REQ-030 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready handshake.
REQ-031 reset pulsed mid-SEARCH for in_value=0xFFFFFFFF -> next cycle IDLE, in_ready=1, out_valid never asserted; next query 8 -> out_index=6, out_is_fib=1.
